// File: rtl/multiword_add_ctrl.sv
// Multi-word adder sequencer: pushes WORDS word pairs through one shared
// WIDTH-bit combinational adder, LSW first, chaining carry through a register.
module multiword_add_ctrl #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH*WORDS-1:0]   a_in,
    input  logic [WIDTH*WORDS-1:0]   b_in,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH*WORDS-1:0]   sum_out,
    output logic                     cout,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_carry
);

    localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        state;
    logic [IDXW-1:0]               idx;
    logic                          carry_reg;
    logic [WORDS-1:0][WIDTH-1:0]   a_reg;
    logic [WORDS-1:0][WIDTH-1:0]   b_reg;
    logic [WORDS-1:0][WIDTH-1:0]   sum_reg;

    // Sequencer: accept, one word per RUN cycle, one-cycle DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        carry_reg <= cin;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int unsigned k = 0; k < WORDS; k++) begin
                        if (idx == IDXW'(k)) begin
                            sum_reg[k] <= add_sum;
                        end
                    end
                    carry_reg <= add_carry;
                    if (idx == IDXW'(WORDS - 1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Shared adder operands are only driven while a word is in flight.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_cin = carry_reg;
            for (int unsigned k = 0; k < WORDS; k++) begin
                if (idx == IDXW'(k)) begin
                    add_a = a_reg[k];
                    add_b = b_reg[k];
                end
            end
        end
    end

    assign sum_out = sum_reg;
    assign cout    = carry_reg;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench for multiword_add_ctrl: vector table, random ops against
// a wide-arithmetic model, and hand sequences for reset/busy/single-word cases.
module tb_multiword_add_ctrl;

    localparam int unsigned W = 24;
    localparam int unsigned N = 4;
    localparam int unsigned T = W * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [T-1:0] a_in, b_in;
    logic         cin;
    logic         busy, done, cout;
    logic [T-1:0] sum_out;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_carry;

    logic         start1;
    logic [W-1:0] a_in1, b_in1;
    logic         busy1, done1, cout1;
    logic [W-1:0] sum_out1;
    logic [W-1:0] add_a1, add_b1, add_sum1;
    logic         add_cin1, add_carry1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared combinational adders living beside each DUT.
    assign {add_carry, add_sum}   = (W+1)'(add_a)  + (W+1)'(add_b)  + (W+1)'(add_cin);
    assign {add_carry1, add_sum1} = (W+1)'(add_a1) + (W+1)'(add_b1) + (W+1)'(add_cin1);

    multiword_add_ctrl #(.WIDTH(W), .WORDS(N)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum_out(sum_out), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_carry(add_carry)
    );

    multiword_add_ctrl #(.WIDTH(W), .WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a_in1), .b_in(b_in1), .cin(1'b0),
        .busy(busy1), .done(done1), .sum_out(sum_out1), .cout(cout1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_carry(add_carry1)
    );

    typedef struct {
        logic [T-1:0] a;
        logic [T-1:0] b;
        logic         c;
        logic [T-1:0] sum;
        logic         co;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a request across one edge, then scramble the inputs.
    task automatic start_op(input logic [T-1:0] a, input logic [T-1:0] b, input logic c);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in = {$urandom, $urandom, $urandom};
        b_in = {$urandom, $urandom, $urandom};
        cin  = 1'($urandom);
    endtask

    // Count edges from acceptance (inclusive) until done is seen; bounded.
    task automatic wait_done(output int edges, output bit cin_ones);
        edges = 1;
        cin_ones = 1'b1;
        while (edges < 30) begin
            @(negedge clk);
            if (done) break;
            if (busy && add_cin !== 1'b1) cin_ones = 1'b0;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic do_op(input string name, input logic [T-1:0] a, input logic [T-1:0] b,
                         input logic c, input logic [T-1:0] es, input logic eco, input bit chk_cin);
        int edges;
        bit cin_ones;
        start_op(a, b, c);
        wait_done(edges, cin_ones);
        check({name, "_latency"}, 128'(edges), 128'(N + 1));
        check({name, "_sum"}, 128'(sum_out), 128'(es));
        check({name, "_cout"}, 128'(cout), 128'(eco));
        if (chk_cin) check({name, "_add_cin_run"}, 128'(cin_ones), 128'(1));
        @(negedge clk);
        check({name, "_done_pulse"}, 128'({done, busy}), 128'(0));
    endtask

    initial begin
        vec_t vecs[4];
        logic [T:0]   ref_full;
        logic [T-1:0] ra, rb, first_sum;
        logic         rc, first_cout;
        int           ndone, last;

        vecs[0] = '{a: 96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF, b: 96'h0, c: 1'b1,
                    sum: 96'h0, co: 1'b1};
        vecs[1] = '{a: 96'h000000_000000_000000_FFFFFF, b: 96'h000000_000000_000000_000001, c: 1'b0,
                    sum: 96'h000000_000000_000001_000000, co: 1'b0};
        vecs[2] = '{a: 96'h800000_800000_800000_800000, b: 96'h800000_800000_800000_800000, c: 1'b0,
                    sum: 96'h000001_000001_000001_000000, co: 1'b1};
        vecs[3] = '{a: 96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF, b: 96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF, c: 1'b1,
                    sum: 96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF, co: 1'b1};

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        start1 = 1'b0; a_in1 = '0; b_in1 = '0;
        repeat (2) @(negedge clk);
        check("rst_sum", 128'(sum_out), 128'(0));
        check("rst_flags", 128'({busy, done, cout, add_cin}), 128'(0));
        check("rst_add", 128'({add_a, add_b}), 128'(0));
        check("rst_w1", 128'({busy1, done1, cout1, sum_out1, add_a1}), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
                  vecs[i].sum, vecs[i].co, i == 0);
        end

        // Random operations against plain wide arithmetic.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            rc = 1'($urandom);
            if (i % 8 == 0) ra = '1;
            ref_full = (T+1)'(ra) + (T+1)'(rb) + (T+1)'(rc);
            do_op($sformatf("rand%0d", i), ra, rb, rc, ref_full[T-1:0], ref_full[T], 1'b0);
        end

        // Start pulses during RUN and DONE must be ignored.
        ra = 96'h123456_789ABC_DEF012_345678;
        rb = 96'h0FEDCB_A98765_432100_FFFFFF;
        ref_full = (T+1)'(ra) + (T+1)'(rb);
        start_op(ra, rb, 1'b0);
        ndone = 0; first_sum = '0; first_cout = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                first_sum = sum_out;
                first_cout = cout;
                start = 1'b1;
                a_in = '1; b_in = '1;
            end else if (i == 1) begin
                start = 1'b1;
                a_in = '1; b_in = '1;
            end
        end
        start = 1'b0;
        check("busy_ignore_ndone", 128'(ndone), 128'(1));
        check("busy_ignore_sum", 128'(first_sum), 128'(ref_full[T-1:0]));
        check("busy_ignore_cout", 128'(first_cout), 128'(ref_full[T]));
        check("busy_ignore_idle", 128'(busy), 128'(0));

        // Asynchronous reset in the 2nd RUN cycle discards the operation.
        start_op(96'hAAAAAA_AAAAAA_AAAAAA_AAAAAA, 96'h111111_111111_111111_111111, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("midrst_partial", 128'(sum_out[W-1:0]), 128'(24'hBBBBBC));
        rst = 1'b1;
        #1;
        check("midrst_sum", 128'(sum_out), 128'(0));
        check("midrst_flags", 128'({busy, done, cout, add_cin}), 128'(0));
        check("midrst_add", 128'({add_a, add_b}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("midrst_no_done", 128'(ndone), 128'(0));
        do_op("after_rst", 96'h000001_000001_000001_000001, 96'h000001_000001_000001_000001,
              1'b0, 96'h000002_000002_000002_000002, 1'b0, 1'b0);

        // Single-word instance with start held high.
        @(negedge clk);
        start1 = 1'b1; a_in1 = 24'h800000; b_in1 = 24'h800000;
        ndone = 0; last = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!busy1 || done1)
                check($sformatf("w1_add_a_idle%0d", i), 128'(add_a1), 128'(0));
            else
                check($sformatf("w1_add_a_run%0d", i), 128'(add_a1), 128'(24'h800000));
            if (done1) begin
                if (last >= 0) check("w1_period", 128'(i - last), 128'(3));
                last = i;
                ndone++;
                check("w1_sum", 128'(sum_out1), 128'(0));
                check("w1_cout", 128'(cout1), 128'(1));
            end
        end
        start1 = 1'b0;
        check("w1_ndone", 128'(ndone), 128'(5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
